// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the main data memory path: default line geometry of
// riscv_dram_data, the arbiter FSM state type and the requester identifiers.
package riscv_mem_pkg;

  // Geometry of the block-RAM data memory (one 128-bit line per address).
  localparam int MEM_DATA_WIDTH = 128;
  localparam int MEM_S_ADDR     = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester identifiers; also the bit positions in the 2-bit request vector.
  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

endpackage

// File: rtl/riscv_dram_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and the data memory.
//   ic_*  : I-cache line refill (read only)
//   dc_*  : D-cache refill read / write-back
//   mem_* : single port of riscv_dram_data (registered read data)
// Modports:
//   slave  - the arbiter (receives requests and mem_rdata, drives acks and mem controls)
//   master - the surrounding system (caches + memory)
interface riscv_dram_arbiter_if #(
  parameter int DATA_WIDTH = 128,
  parameter int S_ADDR     = 10
);
  logic                  ic_req;
  logic [S_ADDR-1:0]     ic_addr;
  logic                  ic_ack;
  logic [DATA_WIDTH-1:0] ic_rdata;

  logic                  dc_req;
  logic                  dc_we;
  logic [S_ADDR-1:0]     dc_addr;
  logic [DATA_WIDTH-1:0] dc_wdata;
  logic                  dc_ack;
  logic [DATA_WIDTH-1:0] dc_rdata;

  logic                  mem_wren;
  logic                  mem_rden;
  logic [S_ADDR-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    output ic_ack, ic_rdata, dc_ack, dc_rdata, mem_wren, mem_rden, mem_addr, mem_wdata
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    input  ic_ack, ic_rdata, dc_ack, dc_rdata, mem_wren, mem_rden, mem_addr, mem_wdata
  );

endinterface

// File: rtl/riscv_rr_arbiter2.sv
// Two-way round-robin grant selection.
//   req_i        : request vector, bit REQ_IC = I-cache, bit REQ_DC = D-cache
//   last_grant_i : requester served by the previous transaction
//   grant_o      : requester to serve next (only meaningful when req_i != 0)
module riscv_rr_arbiter2
  import riscv_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o
);

  always_comb begin
    // NOTE: assign a default before any branch so every path drives grant_o
    // and no latch is inferred.
    grant_o = REQ_IC;
    if (req_i == 2'b11) begin
      // Contention: the requester that did not win last time goes next.
      grant_o = ~last_grant_i;
    end else if (req_i[REQ_DC]) begin
      grant_o = REQ_DC;
    end
  end

endmodule

// File: rtl/riscv_dram_arbiter.sv
// Controller/arbiter for the single port of riscv_dram_data.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of riscv_dram_arbiter_if (ic_*, dc_*, mem_* signals)
//   busy       : high whenever the FSM is not IDLE
// Each transaction is IDLE (sample + latch) -> MEM_LATENCY x ACCESS -> RESP (ack).
module riscv_dram_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int S_ADDR      = MEM_S_ADDR,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_dram_arbiter_if.slave  bus,
  output logic                 busy
);

  localparam int             CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic                  we_q;
  logic [S_ADDR-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mem_wren_q;
  logic                  mem_rden_q;
  logic                  ic_ack_q;
  logic                  dc_ack_q;
  logic [DATA_WIDTH-1:0] ic_rdata_q;
  logic [DATA_WIDTH-1:0] dc_rdata_q;

  logic grant_w;
  logic dc_win_w;
  logic start_write_w;
  logic resp_ic_w;
  logic resp_dc_w;

  riscv_rr_arbiter2 u_arb (
    .req_i        ({bus.dc_req, bus.ic_req}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_w)
  );

  assign dc_win_w      = (grant_w == REQ_DC);
  assign start_write_w = dc_win_w & bus.dc_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= REQ_IC;
      last_grant_q <= REQ_DC;  // I-cache wins the first tie
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_wren_q   <= 1'b0;
      mem_rden_q   <= 1'b0;
      ic_ack_q     <= 1'b0;
      dc_ack_q     <= 1'b0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees the pre-edge values of the others.
      mem_wren_q <= 1'b0;  // write strobe lives for the first ACCESS cycle only
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ic_req || bus.dc_req) begin
            grant_q    <= grant_w;
            we_q       <= start_write_w;
            addr_q     <= dc_win_w ? bus.dc_addr  : bus.ic_addr;
            wdata_q    <= dc_win_w ? bus.dc_wdata : '0;
            cnt_q      <= CNT_LOAD;
            mem_wren_q <= start_write_w;
            mem_rden_q <= ~start_write_w;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            // Acks are registered so they line up with the RESP cycle, when
            // the memory's registered read data is valid.
            mem_rden_q <= 1'b0;
            ic_ack_q   <= (grant_q == REQ_IC);
            dc_ack_q   <= (grant_q == REQ_DC);
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (grant_q == REQ_IC) ic_rdata_q <= bus.mem_rdata;
          else                   dc_rdata_q <= we_q ? '0 : bus.mem_rdata;
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // mem_rdata only becomes valid in RESP, so the granted rdata bus passes it
  // straight through that cycle and replays the captured copy afterwards.
  assign resp_ic_w = (state_q == RESP) && (grant_q == REQ_IC);
  assign resp_dc_w = (state_q == RESP) && (grant_q == REQ_DC);

  assign bus.ic_rdata  = resp_ic_w ? bus.mem_rdata : ic_rdata_q;
  assign bus.dc_rdata  = resp_dc_w ? (we_q ? '0 : bus.mem_rdata) : dc_rdata_q;
  assign bus.ic_ack    = ic_ack_q;
  assign bus.dc_ack    = dc_ack_q;
  assign bus.mem_wren  = mem_wren_q;
  assign bus.mem_rden  = mem_rden_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_dram_arbiter.sv
// Scoreboard bench for riscv_dram_arbiter: one instance with MEM_LATENCY=1 and
// one with MEM_LATENCY=4, each attached to its own behavioural line memory.
module tb_riscv_dram_arbiter;
  import riscv_mem_pkg::*;

  localparam int DW = 128;
  localparam int SA = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_dram_arbiter_if #(.DATA_WIDTH(DW), .S_ADDR(SA)) b1 ();
  riscv_dram_arbiter_if #(.DATA_WIDTH(DW), .S_ADDR(SA)) b4 ();
  logic busy1, busy4;

  riscv_dram_arbiter #(.DATA_WIDTH(DW), .S_ADDR(SA), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .busy(busy1)
  );
  riscv_dram_arbiter #(.DATA_WIDTH(DW), .S_ADDR(SA), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave), .busy(busy4)
  );

  // ---------------- stimulus routing (dsel picks the instance under test)
  logic          dsel;
  logic          t_ic_req, t_dc_req, t_dc_we;
  logic [SA-1:0] t_ic_addr, t_dc_addr;
  logic [DW-1:0] t_dc_wdata;

  assign b1.ic_req   = t_ic_req & ~dsel;
  assign b4.ic_req   = t_ic_req &  dsel;
  assign b1.dc_req   = t_dc_req & ~dsel;
  assign b4.dc_req   = t_dc_req &  dsel;
  assign b1.ic_addr  = t_ic_addr;
  assign b4.ic_addr  = t_ic_addr;
  assign b1.dc_we    = t_dc_we;
  assign b4.dc_we    = t_dc_we;
  assign b1.dc_addr  = t_dc_addr;
  assign b4.dc_addr  = t_dc_addr;
  assign b1.dc_wdata = t_dc_wdata;
  assign b4.dc_wdata = t_dc_wdata;

  logic          o_ic_ack, o_dc_ack, o_wren, o_rden, o_busy;
  logic [DW-1:0] o_ic_rdata, o_dc_rdata, o_wdata;
  logic [SA-1:0] o_addr;

  always_comb begin
    o_ic_ack   = dsel ? b4.ic_ack    : b1.ic_ack;
    o_dc_ack   = dsel ? b4.dc_ack    : b1.dc_ack;
    o_ic_rdata = dsel ? b4.ic_rdata  : b1.ic_rdata;
    o_dc_rdata = dsel ? b4.dc_rdata  : b1.dc_rdata;
    o_wren     = dsel ? b4.mem_wren  : b1.mem_wren;
    o_rden     = dsel ? b4.mem_rden  : b1.mem_rden;
    o_addr     = dsel ? b4.mem_addr  : b1.mem_addr;
    o_wdata    = dsel ? b4.mem_wdata : b1.mem_wdata;
    o_busy     = dsel ? busy4        : busy1;
  end

  // ---------------- behavioural data memories (1-cycle registered read)
  localparam logic [DW-1:0] LINE5 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

  function automatic logic [DW-1:0] preload_val(input logic [SA-1:0] a);
    if (a == 10'h005) return LINE5;
    return {8{6'h2B, a}};
  endfunction

  logic [DW-1:0] mem [2][1024];
  bit            pre_done = 1'b0;

  always @(posedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < 1024; i++) begin
        mem[0][i] <= preload_val(SA'(i));
        mem[1][i] <= preload_val(SA'(i));
      end
      pre_done <= 1'b1;
    end else begin
      if (b1.mem_wren) mem[0][b1.mem_addr] <= b1.mem_wdata;
      if (b1.mem_rden) b1.mem_rdata <= mem[0][b1.mem_addr];
      if (b4.mem_wren) mem[1][b4.mem_addr] <= b4.mem_wdata;
      if (b4.mem_rden) b4.mem_rdata <= mem[1][b4.mem_addr];
    end
  end

  // ---------------- reference model: committed writes per instance
  bit            ref_wr  [2][1024];
  logic [DW-1:0] ref_dat [2][1024];

  function automatic logic [DW-1:0] model_read(input logic d, input logic [SA-1:0] a);
    return ref_wr[d][a] ? ref_dat[d][a] : preload_val(a);
  endfunction

  // ---------------- bookkeeping
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] exp_ic [$];
  logic [DW-1:0] exp_dc [$];
  int            log_who [$];
  int            log_cyc [$];
  int            rden_total = 0;
  int            wren_total = 0;
  int            last_wren_cyc = -1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor: pops the scoreboard whenever an ack appears
  initial begin
    forever begin
      @(negedge clk);
      if (o_wren) begin
        wren_total++;
        last_wren_cyc = cyc;
      end
      if (o_rden) rden_total++;
      if (o_wren || o_rden) check_int("wren_rden_exclusive", int'(o_wren & o_rden), 0);
      if (o_ic_ack || o_dc_ack) check_int("acks_exclusive", int'(o_ic_ack & o_dc_ack), 0);
      if (o_ic_ack) begin
        log_who.push_back(0);
        log_cyc.push_back(cyc);
        if (exp_ic.size() == 0) begin
          total++; bad++;
          $display("FAIL ic_ack_unexpected: got ack want none (cycle %0d)", cyc);
        end else check("ic_rdata", o_ic_rdata, exp_ic.pop_front());
      end
      if (o_dc_ack) begin
        log_who.push_back(1);
        log_cyc.push_back(cyc);
        if (exp_dc.size() == 0) begin
          total++; bad++;
          $display("FAIL dc_ack_unexpected: got ack want none (cycle %0d)", cyc);
        end else check("dc_rdata", o_dc_rdata, exp_dc.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at negedge+1)
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_ic(output int ack_cyc);
    int n = 0;
    ack_cyc = -1;
    while (ack_cyc < 0 && n < 64) begin
      @(negedge clk);
      #1;
      n++;
      if (o_ic_ack) ack_cyc = cyc;
    end
    if (ack_cyc < 0) begin
      total++; bad++;
      $display("FAIL ic_timeout: got no ic_ack want ack within 64 cycles");
    end
    t_ic_req = 1'b0;
  endtask

  task automatic wait_dc(output int ack_cyc);
    int n = 0;
    ack_cyc = -1;
    while (ack_cyc < 0 && n < 64) begin
      @(negedge clk);
      #1;
      n++;
      if (o_dc_ack) ack_cyc = cyc;
    end
    if (ack_cyc < 0) begin
      total++; bad++;
      $display("FAIL dc_timeout: got no dc_ack want ack within 64 cycles");
    end
    t_dc_req = 1'b0;
  endtask

  task automatic run_ic(input logic [SA-1:0] a, output int start, output int ack_cyc);
    exp_ic.push_back(model_read(dsel, a));
    t_ic_addr = a;
    t_ic_req  = 1'b1;
    start     = cyc;
    wait_ic(ack_cyc);
  endtask

  task automatic run_dc(input logic we, input logic [SA-1:0] a, input logic [DW-1:0] d,
                        output int start, output int ack_cyc);
    if (we) begin
      exp_dc.push_back('0);
      ref_wr[dsel][a]  = 1'b1;
      ref_dat[dsel][a] = d;
    end else begin
      exp_dc.push_back(model_read(dsel, a));
    end
    t_dc_we    = we;
    t_dc_addr  = a;
    t_dc_wdata = d;
    t_dc_req   = 1'b1;
    start      = cyc;
    wait_dc(ack_cyc);
  endtask

  // Directed single transaction with timing checks against the latency rule.
  task automatic directed_dc(input string tag, input logic we, input logic [SA-1:0] a,
                             input logic [DW-1:0] d, input int lat);
    int s, c, r0, w0;
    r0 = rden_total;
    w0 = wren_total;
    run_dc(we, a, d, s, c);
    check_int({tag, "_latency"}, c - s, lat + 1);
    if (we) begin
      check_int({tag, "_wren_cycles"}, wren_total - w0, 1);
      check_int({tag, "_wren_first_access"}, last_wren_cyc, s + 1);
      check_int({tag, "_rden_cycles"}, rden_total - r0, 0);
    end else begin
      check_int({tag, "_rden_cycles"}, rden_total - r0, lat);
      check_int({tag, "_wren_cycles"}, wren_total - w0, 0);
    end
  endtask

  // ---------------- main sequence
  initial begin
    int c_ic, c_dc, s, c, n0;
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};

    dsel = 1'b0;
    rst_n = 1'b0;
    t_ic_req = 1'b1; t_ic_addr = 10'h020;
    t_dc_req = 1'b1; t_dc_addr = 10'h021; t_dc_we = 1'b0; t_dc_wdata = '0;

    // Reset with both requests asserted: everything quiet.
    idle(3);
    check_int("rst_ic_ack", int'(o_ic_ack), 0);
    check_int("rst_dc_ack", int'(o_dc_ack), 0);
    check("rst_ic_rdata", o_ic_rdata, '0);
    check("rst_dc_rdata", o_dc_rdata, '0);
    check_int("rst_mem_wren", int'(o_wren), 0);
    check_int("rst_mem_rden", int'(o_rden), 0);
    check_int("rst_mem_addr", int'(o_addr), 0);
    check("rst_mem_wdata", o_wdata, '0);
    check_int("rst_busy", int'(o_busy), 0);
    check_int("rst_busy4", int'(busy4), 0);

    // Release with both pending: I-cache must be served first.
    exp_ic.push_back(model_read(1'b0, 10'h020));
    exp_dc.push_back(model_read(1'b0, 10'h021));
    rst_n = 1'b1;
    fork
      wait_ic(c_ic);
      wait_dc(c_dc);
    join
    check_int("tie_ic_first", int'(c_ic < c_dc), 1);

    // Single refill read of the preloaded line 0x05.
    idle(2);
    directed_dc("rd05", 1'b0, 10'h005, '0, 1);

    // Contention: three back-to-back requests from each side.
    n0 = log_who.size();
    fork
      begin
        int ls, lc;
        repeat (3) run_ic(SA'($urandom_range(0, 511)), ls, lc);
      end
      begin
        int ls, lc;
        repeat (3) run_dc(1'b0, SA'(512 + $urandom_range(0, 511)), '0, ls, lc);
      end
    join
    check_int("cont_ack_count", log_who.size() - n0, 6);
    if (log_who.size() - n0 >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check_int($sformatf("cont_grant%0d", i), log_who[n0+i], i % 2);
        if (i > 0) check_int($sformatf("cont_spacing%0d", i), log_cyc[n0+i] - log_cyc[n0+i-1], 3);
      end
    end

    // Write-back to the top line, then I-cache read-back of the same line.
    idle(2);
    directed_dc("wr3ff", 1'b1, 10'h3FF, a5, 1);
    idle(2);
    run_ic(10'h3FF, s, c);
    check_int("rb3ff_latency", c - s, 2);

    // Randomised traffic: I-cache reads the low half, D-cache owns a small
    // window of the upper half so the two streams never alias.
    fork
      begin
        int ls, lc;
        repeat (20) begin
          idle($urandom_range(0, 3));
          run_ic(SA'($urandom_range(0, 511)), ls, lc);
        end
      end
      begin
        int ls, lc;
        repeat (20) begin
          idle($urandom_range(0, 3));
          run_dc(1'($urandom_range(0, 1)), SA'(512 + $urandom_range(0, 7)),
                 {$urandom(), $urandom(), $urandom(), $urandom()}, ls, lc);
        end
      end
    join
    check_int("sb_ic_empty", exp_ic.size(), 0);
    check_int("sb_dc_empty", exp_dc.size(), 0);

    // Reset during the first ACCESS cycle of a write to 0x10.
    idle(3);
    t_dc_we = 1'b1; t_dc_addr = 10'h010; t_dc_wdata = {16{8'h5A}}; t_dc_req = 1'b1;
    @(negedge clk);
    check_int("abort_in_access", int'(o_wren), 1);
    rst_n = 1'b0;
    #1;
    t_dc_req = 1'b0;
    check_int("abort_wren_cleared", int'(o_wren), 0);
    idle(1);
    rst_n = 1'b1;
    idle(3);
    check_int("abort_busy_idle", int'(o_busy), 0);
    run_ic(10'h010, s, c);  // model untouched: line must still hold its preload

    // MEM_LATENCY = 4 instance.
    dsel = 1'b1;
    idle(3);
    directed_dc("l4_rd05", 1'b0, 10'h005, '0, 4);
    idle(2);
    directed_dc("l4_wr123", 1'b1, 10'h123, {$urandom(), $urandom(), $urandom(), $urandom()}, 4);
    idle(2);
    run_ic(10'h123, s, c);
    check_int("l4_rb_latency", c - s, 5);

    idle(3);
    check_int("final_ic_empty", exp_ic.size(), 0);
    check_int("final_dc_empty", exp_dc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish within 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
